// File: rtl/traffic_ctrl_pkg.sv
// Shared types and constants for the two-road traffic light controller.
package traffic_ctrl_pkg;

    localparam int unsigned REMAIN_W = 6;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic [2:0] {
        ST_MG  = 3'd0,
        ST_MY  = 3'd1,
        ST_AR1 = 3'd2,
        ST_SG  = 3'd3,
        ST_SY  = 3'd4,
        ST_AR2 = 3'd5,
        ST_EMR = 3'd6
    } state_t;

    // {main, side} lamps for a state; unknown encodings show all red.
    function automatic logic [5:0] lamp_pair(input state_t s);
        case (s)
            ST_MG:   lamp_pair = {LAMP_G, LAMP_R};
            ST_MY:   lamp_pair = {LAMP_Y, LAMP_R};
            ST_SG:   lamp_pair = {LAMP_R, LAMP_G};
            ST_SY:   lamp_pair = {LAMP_R, LAMP_Y};
            default: lamp_pair = {LAMP_R, LAMP_R};
        endcase
    endfunction

endpackage

// File: rtl/traffic_ctrl_phase_cnt.sv
// Tick-driven loadable down-counter; load wins over decrement, never goes below 1.
module phase_cnt #(
    parameter int unsigned W       = 6,
    parameter int unsigned RST_VAL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_last_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= W'(RST_VAL);
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt > W'(1))) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_last_c = (r_cnt == W'(1));

endmodule

// File: rtl/traffic_ctrl.sv
// Main/side road traffic light sequencer with emergency all-red hold.
module traffic_ctrl
    import traffic_ctrl_pkg::*;
#(
    parameter int unsigned T_MG = 30,
    parameter int unsigned T_MY = 3,
    parameter int unsigned T_SG = 20,
    parameter int unsigned T_SY = 3,
    parameter int unsigned T_AR = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                emerg,
    output logic [2:0]          main_ryg,
    output logic [2:0]          side_ryg,
    output logic [REMAIN_W-1:0] remain
);

    localparam logic [REMAIN_W-1:0] L_MG = REMAIN_W'(T_MG);
    localparam logic [REMAIN_W-1:0] L_MY = REMAIN_W'(T_MY);
    localparam logic [REMAIN_W-1:0] L_SG = REMAIN_W'(T_SG);
    localparam logic [REMAIN_W-1:0] L_SY = REMAIN_W'(T_SY);
    localparam logic [REMAIN_W-1:0] L_AR = REMAIN_W'(T_AR);

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_seq_nxt;
    logic [REMAIN_W-1:0] w_seq_dur;
    logic                w_timed;
    logic                w_load;
    logic [REMAIN_W-1:0] w_load_val;
    logic                w_dec;
    logic                w_last_c;
    logic [2:0]          r_main_ryg;
    logic [2:0]          r_side_ryg;

    phase_cnt #(
        .W       (REMAIN_W),
        .RST_VAL (T_MG)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_cnt      (remain),
        .o_last_c   (w_last_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_MG;
            r_main_ryg <= LAMP_G;
            r_side_ryg <= LAMP_R;
        end else begin
            r_state                  <= w_state_nxt;
            {r_main_ryg, r_side_ryg} <= lamp_pair(w_state_nxt);
        end
    end

    // Successor and its duration for each timed phase of the normal cycle.
    always_comb begin
        w_seq_nxt = ST_MG;
        w_seq_dur = L_MG;
        w_timed   = 1'b1;
        case (r_state)
            ST_MG:   begin w_seq_nxt = ST_MY;  w_seq_dur = L_MY; end
            ST_MY:   begin w_seq_nxt = ST_AR1; w_seq_dur = L_AR; end
            ST_AR1:  begin w_seq_nxt = ST_SG;  w_seq_dur = L_SG; end
            ST_SG:   begin w_seq_nxt = ST_SY;  w_seq_dur = L_SY; end
            ST_SY:   begin w_seq_nxt = ST_AR2; w_seq_dur = L_AR; end
            ST_AR2:  begin w_seq_nxt = ST_MG;  w_seq_dur = L_MG; end
            default: w_timed = 1'b0;
        endcase
    end

    // Emergency entry takes priority over any tick in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_dec       = 1'b0;
        if (emerg && (r_state != ST_EMR)) begin
            w_state_nxt = ST_EMR;
            w_load      = 1'b1;
        end else if (r_state == ST_EMR) begin
            if (!emerg) begin
                w_state_nxt = ST_AR2;
                w_load      = 1'b1;
                w_load_val  = L_AR;
            end
        end else if (!w_timed) begin
            w_state_nxt = ST_MG;
            w_load      = 1'b1;
            w_load_val  = L_MG;
        end else if (tick) begin
            if (w_last_c) begin
                w_state_nxt = w_seq_nxt;
                w_load      = 1'b1;
                w_load_val  = w_seq_dur;
            end else begin
                w_dec = 1'b1;
            end
        end
    end

    assign main_ryg = r_main_ryg;
    assign side_ryg = r_side_ryg;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl with shortened phase durations.
module tb_traffic_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       emerg;
    logic [2:0] main_ryg;
    logic [2:0] side_ryg;
    logic [5:0] remain;

    int total = 0;
    int bad   = 0;

    localparam int S_MG = 0, S_MY = 1, S_AR = 2, S_SG = 3, S_SY = 4;

    traffic_ctrl #(
        .T_MG (4), .T_MY (2), .T_SG (3), .T_SY (2), .T_AR (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .emerg    (emerg),
        .main_ryg (main_ryg),
        .side_ryg (side_ryg),
        .remain   (remain)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int st, input int rem);
        logic [2:0] em, es;
        case (st)
            S_MG:    begin em = 3'b001; es = 3'b100; end
            S_MY:    begin em = 3'b010; es = 3'b100; end
            S_SG:    begin em = 3'b100; es = 3'b001; end
            S_SY:    begin em = 3'b100; es = 3'b010; end
            default: begin em = 3'b100; es = 3'b100; end
        endcase
        total++;
        assert ({main_ryg, side_ryg, remain} === {em, es, 6'(rem)}) else begin
            bad++;
            $error("FAIL %s: got main=%b side=%b remain=%0d, expected main=%b side=%b remain=%0d",
                   tag, main_ryg, side_ryg, remain, em, es, rem);
        end
    endtask

    // Apply inputs for one clock edge, then settle 1 time unit past it.
    task automatic cyc(input logic tk, input logic em);
        tick  = tk;
        emerg = em;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    initial begin
        int seq_st [15] = '{S_MG, S_MG, S_MG, S_MY, S_MY, S_AR, S_SG, S_SG, S_SG,
                            S_SY, S_SY, S_AR, S_MG, S_MG, S_MG};
        int seq_rm [15] = '{3, 2, 1, 2, 1, 1, 3, 2, 1, 2, 1, 1, 4, 3, 2};
        int max_st [8]  = '{S_MG, S_MG, S_MG, S_MY, S_MY, S_AR, S_SG, S_SG};
        int max_rm [8]  = '{3, 2, 1, 2, 1, 1, 3, 2};

        rst   = 1'b1;
        tick  = 1'b0;
        emerg = 1'b0;
        #2;
        chk("reset_async", S_MG, 4);
        @(posedge clk); #1;
        chk("reset_held", S_MG, 4);
        rst = 1'b0;

        // Full cycle, ticks spaced 5 clocks apart.
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 1'b0);
            repeat (4) cyc(1'b0, 1'b0);
            chk($sformatf("seq_tick%0d", i + 1), seq_st[i], seq_rm[i]);
        end

        // Maximum tick rate straight out of reset.
        rst = 1'b1;
        #1;
        chk("reset_midphase", S_MG, 4);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0);
            chk($sformatf("maxrate_clk%0d", i + 1), max_st[i], max_rm[i]);
        end

        // Emergency coincident with a tick in SG(2); the tick is discarded.
        cyc(1'b1, 1'b1);
        chk("emerg_enter", S_AR, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1);
            chk($sformatf("emerg_hold%0d", i + 1), S_AR, 0);
        end
        cyc(1'b0, 1'b0);
        chk("emerg_release", S_AR, 1);
        cyc(1'b1, 1'b0);
        chk("after_ar2", S_MG, 4);

        // Walk to SY and reset asynchronously between edges.
        repeat (10) cyc(1'b1, 1'b0);
        chk("reach_sy", S_SY, 2);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_sy", S_MG, 4);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_hold", S_MG, 4);
        cyc(1'b1, 1'b0);
        chk("first_tick_after_rst", S_MG, 3);

        // Emergency from MG without tick, then release.
        cyc(1'b0, 1'b1);
        chk("emerg_from_mg", S_AR, 0);
        cyc(1'b0, 1'b0);
        chk("emerg_from_mg_rel", S_AR, 1);
        cyc(1'b1, 1'b0);
        chk("emerg_from_mg_mg", S_MG, 4);

        // Long idle in MY.
        repeat (4) cyc(1'b1, 1'b0);
        chk("reach_my", S_MY, 2);
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b0, 1'b0);
            if ((i % 100) == 99) chk($sformatf("idle_my%0d", i + 1), S_MY, 2);
        end
        cyc(1'b1, 1'b0);
        chk("my_after_idle", S_MY, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
